// File: rtl/dmem_arb_pkg.sv
// Shared constants, lock-state encoding and range helper for the
// data-memory arbiter slice.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 1024;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

    function automatic logic in_range(
        input logic [31:0] a,
        input logic [31:0] depth
    );
        return a < depth;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// Ports: req[1:0], prio in; gnt[1:0] one-hot out, nxt_prio = loser index.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt,
    output logic       nxt_prio
);

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            req == 2'b11: gnt = prio ? 2'b10 : 2'b01;
            req == 2'b01: gnt = 2'b01;
            req == 2'b10: gnt = 2'b10;
            default:      gnt = 2'b00;
        endcase
    end

    // The loser of this cycle gets priority next time.
    always_comb begin
        nxt_prio = prio;
        if (gnt[0])
            nxt_prio = PORT1;
        else if (gnt[1])
            nxt_prio = PORT0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between two requesters.
// Ports: clk, rst (async high); req/we/addr/wdata per port in; gnt,
// rvalid, rdata, err per port out; mem_a/mem_we/mem_wd out, mem_rd in.
// Optional DMEM_ARB_LOCK_EN adds lock0/lock1 and an ownership FSM.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic              prio;
    logic              nxt_prio;
    logic [1:0]        req_v;
    logic [1:0]        gnt_v;
    logic              any_g;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;
    logic              in_rng;
    logic              rd0;
    logic              rd1;

`ifdef DMEM_ARB_LOCK_EN
    lock_state_t state;
    lock_state_t nxt_state;
    logic        prio_upd;
    logic        prio_val;

    // The owner's partner is masked off while a lock is held.
    always_comb begin
        req_v = {req1, req0};
        unique case (state)
            OWN0:    req_v[1] = 1'b0;
            OWN1:    req_v[0] = 1'b0;
            default: req_v    = {req1, req0};
        endcase
    end
`else
    assign req_v = {req1, req0};
`endif

    rr_arb2 u_rr (
        .req      (req_v),
        .prio     (prio),
        .gnt      (gnt_v),
        .nxt_prio (nxt_prio)
    );

    // Grants are suppressed during reset so nothing commits then.
    assign gnt0  = gnt_v[0] & ~rst;
    assign gnt1  = gnt_v[1] & ~rst;
    assign any_g = gnt0 | gnt1;

    assign sel_we   = gnt1 ? we1    : we0;
    assign sel_addr = gnt1 ? addr1  : addr0;
    assign sel_wd   = gnt1 ? wdata1 : wdata0;
    assign in_rng   = in_range(32'(sel_addr), 32'(DEPTH));

    assign mem_a  = any_g ? sel_addr : '0;
    assign mem_wd = any_g ? sel_wd   : '0;
    assign mem_we = any_g & sel_we & in_rng;

    assign rd0 = gnt0 & ~we0 & in_rng;
    assign rd1 = gnt1 & ~we1 & in_rng;

`ifdef DMEM_ARB_LOCK_EN
    always_comb begin
        nxt_state = state;
        prio_upd  = 1'b0;
        prio_val  = nxt_prio;
        unique case (state)
            IDLE: begin
                if (gnt0 & lock0)
                    nxt_state = OWN0;
                else if (gnt1 & lock1)
                    nxt_state = OWN1;
                else if (any_g)
                    prio_upd = 1'b1;
            end
            OWN0: begin
                if ((gnt0 | ~req0) & ~lock0) begin
                    nxt_state = IDLE;
                    prio_upd  = 1'b1;
                    prio_val  = PORT1;
                end
            end
            OWN1: begin
                if ((gnt1 | ~req1) & ~lock1) begin
                    nxt_state = IDLE;
                    prio_upd  = 1'b1;
                    prio_val  = PORT0;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= PORT0;
        end else begin
            state <= nxt_state;
            if (prio_upd)
                prio <= prio_val;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= PORT0;
        else if (any_g)
            prio <= nxt_prio;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= rd0;
            rvalid1 <= rd1;
            err0    <= gnt0 & ~in_rng;
            err1    <= gnt1 & ~in_rng;
            if (rd0)
                rdata0 <= mem_rd;
            if (rd1)
                rdata1 <= mem_rd;
        end
    end

endmodule
